data_memory_pipe: RTL and testbench

//  Parametrised single-port, byte-addressed data memory for the CPU load/store stage.

---
 rtl/data_memory_pipe_if.sv | 32 +++
 rtl/data_memory_pipe.sv | 108 ++++++++++
 tb/tb_data_memory_pipe.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_pipe_if.sv
// data_memory_pipe_if: request/response bus of the load/store data memory
//   req_valid/req_ready : request handshake, a request is taken when both are high at a rising edge
//   req_write           : 1 store, 0 load
//   req_size            : 00 byte, 01 half, 10 word, 11 dword
//   req_unsigned        : zero-extend loads when 1, sign-extend when 0
//   req_addr/req_wdata  : byte address and right-aligned store data
//   rsp_valid/rsp_rdata/rsp_err : fixed-latency in-order response, no backpressure
interface data_memory_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_memory_pipe.sv
// data_memory_pipe: byte-addressed single-port data memory with fixed-latency response pipe
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; flushes the pipe and reruns the array clear
//   bus   : data_memory_pipe_if slave (request handshake in, response out)
module data_memory_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    data_memory_pipe_if.slave bus
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF   = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {INIT, RUN} state_t;

    state_t                         r_state;
    logic [IDX_W-1:0]               r_clr;
    logic                           r_ready;
    logic [DATA_W-1:0]              r_mem [DEPTH];
    logic [RD_LAT-1:0]              r_pv;
    logic [RD_LAT-1:0]              r_pe;
    logic [RD_LAT-1:0][DATA_W-1:0]  r_pd;

    logic [OFF-1:0]    w_off;
    logic [IDX_W-1:0]  w_idx;
    logic              w_acc;
    logic              w_err;
    logic [7:0]        w_lanes;
    logic [NB-1:0]     w_be;
    logic [DATA_W-1:0] w_wsh;
    logic [DATA_W-1:0] w_rd;
    logic [DATA_W-1:0] w_sh;
    logic [DATA_W-1:0] w_m;
    logic [DATA_W-1:0] w_ld;
    logic              w_sign;
    logic              w_unused;

    assign w_off    = bus.req_addr[OFF-1:0];
    assign w_idx    = bus.req_addr[OFF +: IDX_W];
    assign w_unused = |(bus.req_addr >> (OFF + IDX_W));
    assign w_acc    = bus.req_valid & r_ready;
    assign w_err    = bus.req_size == 2'd1 ? w_off[0] :
                      bus.req_size == 2'd2 ? |w_off[1:0] :
                      bus.req_size == 2'd3 ? (DATA_W == 32) | (|bus.req_addr[2:0]) : 1'b0;

    // 2^size bytes selected, placed at the byte offset inside the word
    assign w_lanes  = 8'((9'd1 << (4'd1 << bus.req_size)) - 9'd1);
    assign w_be     = NB'({8'd0, w_lanes} << w_off);
    assign w_wsh    = bus.req_wdata << {w_off, 3'b000};

    // Load path: shift selected lanes down, mask to size, fill above with the top selected bit
    assign w_rd     = r_mem[w_idx];
    assign w_sh     = w_rd >> {w_off, 3'b000};
    assign w_m      = (DATA_W'(1) << (7'd8 << bus.req_size)) - DATA_W'(1);
    assign w_sign   = ~bus.req_unsigned & |(w_sh & (w_m ^ (w_m >> 1)));
    assign w_ld     = (w_sh & w_m) | (w_sign ? ~w_m : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= INIT;
            r_clr   <= '0;
            r_ready <= 1'b0;
        end else if (r_state == INIT) begin
            r_clr <= r_clr + 1'b1;
            if (r_clr == IDX_W'(DEPTH - 1)) begin
                r_state <= RUN;
                r_ready <= 1'b1;
            end
        end
    end

    // Array has no reset; the INIT sweep clears one word per cycle instead
    always_ff @(posedge clk) begin
        if (r_state == INIT)
            r_mem[r_clr] <= '0;
        else if (w_acc & bus.req_write & ~w_err)
            for (int b = 0; b < NB; b++)
                if (w_be[b])
                    r_mem[w_idx][8*b +: 8] <= w_wsh[8*b +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv <= '0;
            r_pe <= '0;
            r_pd <= '0;
        end else begin
            r_pv[0] <= w_acc;
            r_pe[0] <= w_acc & w_err;
            r_pd[0] <= (w_acc & ~bus.req_write & ~w_err) ? w_ld : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pe[i] <= r_pe[i-1];
                r_pd[i] <= r_pd[i-1];
            end
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.rsp_valid = r_pv[RD_LAT-1];
    assign bus.rsp_err   = r_pe[RD_LAT-1];
    assign bus.rsp_rdata = r_pd[RD_LAT-1];
endmodule

// File: tb/tb_data_memory_pipe.sv
// tb_data_memory_pipe: directed self-checking bench for data_memory_pipe (RD_LAT=1 and RD_LAT=3 instances)
module tb_data_memory_pipe;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    data_memory_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) b1 ();
    data_memory_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) b3 ();

    data_memory_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1.slave)
    );

    data_memory_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b3.slave)
    );

    task automatic idle();
        b1.req_valid = 0; b1.req_write = 0; b1.req_size = 0; b1.req_unsigned = 0;
        b1.req_addr = 0; b1.req_wdata = 0;
        b3.req_valid = 0; b3.req_write = 0; b3.req_size = 0; b3.req_unsigned = 0;
        b3.req_addr = 0; b3.req_wdata = 0;
    endtask

    // One request on the RD_LAT=1 instance; response sampled on the negedge after acceptance
    task automatic issue(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                         input logic [31:0] wd, output logic v, output logic [31:0] rd, output logic e);
        @(negedge clk);
        b1.req_valid = 1; b1.req_write = w; b1.req_size = sz; b1.req_unsigned = u;
        b1.req_addr = a; b1.req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        v = b1.rsp_valid; rd = b1.rsp_rdata; e = b1.rsp_err;
        b1.req_valid = 0;
    endtask

    task automatic test_reset();
        int cnt;
        logic v, e;
        logic [31:0] rd;
        idle();
        #1 rst_n = 0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (b1.req_ready !== 0 || b1.rsp_valid !== 0 || b1.rsp_rdata !== 0 || b1.rsp_err !== 0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rdy=%b v=%b d=%h e=%b want 0 0 0 0",
                     b1.req_ready, b1.rsp_valid, b1.rsp_rdata, b1.rsp_err);
        end
        rst_n = 1;
        cnt = 0;
        while (b1.req_ready !== 1 && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        n_cmp++;
        if (cnt !== DEPTH) begin
            n_bad++;
            $display("FAIL init_length: got %0d cycles want %0d", cnt, DEPTH);
        end
        issue(0, 2'd2, 0, 32'h44, 0, v, rd, e);
        n_cmp++;
        if (v !== 1 || rd !== 32'h0 || e !== 0) begin
            n_bad++;
            $display("FAIL load_after_init: got v=%b d=%h e=%b want 1 00000000 0", v, rd, e);
        end
    endtask

    task automatic test_load_ext();
        logic v, e;
        logic [31:0] rd;
        issue(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, v, rd, e);
        n_cmp++;
        if (v !== 1 || rd !== 32'h0 || e !== 0) begin
            n_bad++;
            $display("FAIL store_rsp: got v=%b d=%h e=%b want 1 00000000 0", v, rd, e);
        end
        issue(0, 2'd0, 0, 32'h11, 0, v, rd, e);
        n_cmp++;
        if (v !== 1 || rd !== 32'hFFFFFFBE || e !== 0) begin
            n_bad++;
            $display("FAIL ld_byte_s: got v=%b d=%h e=%b want 1 ffffffbe 0", v, rd, e);
        end
        issue(0, 2'd0, 1, 32'h11, 0, v, rd, e);
        n_cmp++;
        if (v !== 1 || rd !== 32'h000000BE || e !== 0) begin
            n_bad++;
            $display("FAIL ld_byte_u: got v=%b d=%h e=%b want 1 000000be 0", v, rd, e);
        end
        issue(0, 2'd1, 0, 32'h12, 0, v, rd, e);
        n_cmp++;
        if (v !== 1 || rd !== 32'hFFFFDEAD || e !== 0) begin
            n_bad++;
            $display("FAIL ld_half_s: got v=%b d=%h e=%b want 1 ffffdead 0", v, rd, e);
        end
        issue(0, 2'd1, 0, 32'h10, 0, v, rd, e);
        n_cmp++;
        if (v !== 1 || rd !== 32'hFFFFBEEF || e !== 0) begin
            n_bad++;
            $display("FAIL ld_half_lo_s: got v=%b d=%h e=%b want 1 ffffbeef 0", v, rd, e);
        end
        issue(0, 2'd0, 0, 32'h10, 0, v, rd, e);
        n_cmp++;
        if (v !== 1 || rd !== 32'hFFFFFFEF || e !== 0) begin
            n_bad++;
            $display("FAIL ld_byte0_s: got v=%b d=%h e=%b want 1 ffffffef 0", v, rd, e);
        end
    endtask

    task automatic test_back_to_back();
        logic v, e;
        logic [31:0] rd;
        @(negedge clk);
        b1.req_valid = 1; b1.req_write = 1; b1.req_size = 2'd0; b1.req_unsigned = 0;
        b1.req_addr = 32'h13; b1.req_wdata = 32'hAAAAAA55;
        @(negedge clk);
        n_cmp++;
        if (b1.rsp_valid !== 1 || b1.rsp_rdata !== 32'h0 || b1.rsp_err !== 0) begin
            n_bad++;
            $display("FAIL b2b_store_rsp: got v=%b d=%h e=%b want 1 00000000 0",
                     b1.rsp_valid, b1.rsp_rdata, b1.rsp_err);
        end
        b1.req_write = 0; b1.req_size = 2'd2; b1.req_addr = 32'h10;
        @(negedge clk);
        b1.req_valid = 0;
        n_cmp++;
        if (b1.rsp_valid !== 1 || b1.rsp_rdata !== 32'h55ADBEEF || b1.rsp_err !== 0) begin
            n_bad++;
            $display("FAIL b2b_load: got v=%b d=%h e=%b want 1 55adbeef 0",
                     b1.rsp_valid, b1.rsp_rdata, b1.rsp_err);
        end
        issue(1, 2'd1, 0, 32'h16, 32'hFFFF1234, v, rd, e);
        issue(0, 2'd2, 0, 32'h14, 0, v, rd, e);
        n_cmp++;
        if (v !== 1 || rd !== 32'h12340000 || e !== 0) begin
            n_bad++;
            $display("FAIL half_lane_store: got v=%b d=%h e=%b want 1 12340000 0", v, rd, e);
        end
    endtask

    task automatic test_misaligned();
        logic v, e;
        logic [31:0] rd;
        issue(1, 2'd2, 0, 32'h20, 32'h11223344, v, rd, e);
        issue(1, 2'd2, 0, 32'h22, 32'hCAFEF00D, v, rd, e);
        n_cmp++;
        if (v !== 1 || rd !== 32'h0 || e !== 1) begin
            n_bad++;
            $display("FAIL misaligned_store: got v=%b d=%h e=%b want 1 00000000 1", v, rd, e);
        end
        issue(0, 2'd2, 0, 32'h20, 0, v, rd, e);
        n_cmp++;
        if (v !== 1 || rd !== 32'h11223344 || e !== 0) begin
            n_bad++;
            $display("FAIL misaligned_unchanged: got v=%b d=%h e=%b want 1 11223344 0", v, rd, e);
        end
        issue(1, 2'd3, 0, 32'h20, 32'hFFFFFFFF, v, rd, e);
        n_cmp++;
        if (v !== 1 || rd !== 32'h0 || e !== 1) begin
            n_bad++;
            $display("FAIL dword_store_err: got v=%b d=%h e=%b want 1 00000000 1", v, rd, e);
        end
        issue(0, 2'd1, 0, 32'h21, 0, v, rd, e);
        n_cmp++;
        if (v !== 1 || rd !== 32'h0 || e !== 1) begin
            n_bad++;
            $display("FAIL misaligned_half_load: got v=%b d=%h e=%b want 1 00000000 1", v, rd, e);
        end
        issue(0, 2'd2, 0, 32'h20, 0, v, rd, e);
        n_cmp++;
        if (v !== 1 || rd !== 32'h11223344 || e !== 0) begin
            n_bad++;
            $display("FAIL dword_unchanged: got v=%b d=%h e=%b want 1 11223344 0", v, rd, e);
        end
    endtask

    task automatic test_wrap();
        logic v, e;
        logic [31:0] rd;
        issue(1, 2'd2, 0, 32'h400, 32'h12345678, v, rd, e);
        issue(0, 2'd2, 0, 32'h000, 0, v, rd, e);
        n_cmp++;
        if (v !== 1 || rd !== 32'h12345678 || e !== 0) begin
            n_bad++;
            $display("FAIL wrap_load: got v=%b d=%h e=%b want 1 12345678 0", v, rd, e);
        end
    endtask

    // RD_LAT=3: 2 stores then 10 loads back to back; request k accepted at the posedge after
    // negedge k, so its response is sampled at negedge k+3
    task automatic test_latency();
        int j;
        logic ev;
        logic [31:0] ed;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            j  = k - 3;
            ev = (j >= 0 && j < 12);
            ed = (j == 2) ? 32'hA5A5A5A5 : (j == 4) ? 32'h13579BDF : 32'h0;
            n_cmp++;
            if (b3.rsp_valid !== ev || b3.rsp_rdata !== ed || b3.rsp_err !== 0) begin
                n_bad++;
                $display("FAIL lat3_cycle%0d: got v=%b d=%h e=%b want %b %h 0",
                         k, b3.rsp_valid, b3.rsp_rdata, b3.rsp_err, ev, ed);
            end
            b3.req_valid   = (k < 12);
            b3.req_write   = (k < 2);
            b3.req_size    = 2'd2;
            b3.req_addr    = (k == 0) ? 32'h0 : (k == 1) ? 32'h8 : 32'(4 * (k - 2));
            b3.req_wdata   = (k == 0) ? 32'hA5A5A5A5 : 32'h13579BDF;
        end
        b3.req_valid = 0;
    endtask

    task automatic test_reset_midstream();
        int cnt;
        logic saw;
        logic v, e;
        logic [31:0] rd;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 0;
            #1;
            if (k >= 2) begin
                n_cmp++;
                if (b3.rsp_valid !== 0) begin
                    n_bad++;
                    $display("FAIL midreset_no_rsp%0d: got v=%b want 0", k, b3.rsp_valid);
                end
            end
            b3.req_valid = 1; b3.req_write = 0; b3.req_size = 2'd2; b3.req_addr = 32'h0;
        end
        @(negedge clk);
        rst_n = 1;
        cnt = 0;
        saw = 0;
        while (b3.req_ready !== 1 && cnt < 1000) begin
            saw |= b3.rsp_valid;
            cnt++;
            @(negedge clk);
        end
        b3.req_valid = 0;
        n_cmp++;
        if (cnt !== DEPTH || saw !== 0) begin
            n_bad++;
            $display("FAIL reinit: got %0d cycles saw_rsp=%b want %0d 0", cnt, saw, DEPTH);
        end
        issue(0, 2'd2, 0, 32'h10, 0, v, rd, e);
        n_cmp++;
        if (v !== 1 || rd !== 32'h0 || e !== 0) begin
            n_bad++;
            $display("FAIL reinit_cleared: got v=%b d=%h e=%b want 1 00000000 0", v, rd, e);
        end
    endtask

    initial begin
        test_reset();
        test_load_ext();
        test_back_to_back();
        test_misaligned();
        test_wrap();
        test_latency();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
